step_scheduler: RTL and testbench

Play-mode timing controller for the drum-machine datapath. It generates the step position, step-start pulse and per-step gate window from the 2 MHz system clock. It also produces the registered 4-bit sample-enable vector that drives the kick/clap/hihat/snare sample players. It replaces the free-running divider, play sequencer and gate counter in `top`. Tempo and gate length are runtime inputs, and both are applied glitch-free at step boundaries.

---
 rtl/drum_pkg.sv | 25 ++
 rtl/step_timer.sv | 99 +++++++++
 rtl/step_scheduler.sv | 135 +++++++++++++
 tb/tb_step_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared types and constants for the drum-machine datapath: sample-enable
// vector layout, scheduler state encoding and nominal tempo/gate settings.
package drum_pkg;

    typedef logic [3:0] smpl_t;

    localparam int KICK  = 3;
    localparam int CLAP  = 2;
    localparam int HIHAT = 1;
    localparam int SNARE = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam logic [19:0] STEP_PERIOD_120BPM = 20'd999999;
    localparam logic [19:0] GATE_90PCT         = 20'd900000;

    // Pattern bits pass only while the step gate is open.
    function automatic smpl_t gate_smpl(input logic g, input smpl_t s);
        return g ? s : 4'b0000;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step cycle counter with boundary reload and registered gate window.
// Optional STEP_SCHEDULER_SWING_EN lengthens even steps and shortens odd ones.
module step_timer
    import drum_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic             i_hold,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_gate_len,
`ifdef STEP_SCHEDULER_SWING_EN
    input  logic [CNT_W-1:0] i_swing,
`endif
    output logic             o_last,
    output logic             o_gate
);

    // One extra bit so period+swing cannot wrap.
    localparam int W = CNT_W + 1;

    logic [W-1:0]     r_cnt;
    logic [W-1:0]     w_cnt_inc;
    logic [W-1:0]     w_term;
    logic [CNT_W-1:0] r_period_q;
    logic [CNT_W-1:0] r_gate_q;
    logic             r_gate;
`ifdef STEP_SCHEDULER_SWING_EN
    logic             r_odd;
    logic [CNT_W-1:0] r_swing_q;
    logic [CNT_W-1:0] w_swing_clamp;
`endif

    // Terminal count for the current step and the next counter value.
    always_comb begin
        w_cnt_inc = r_cnt + W'(1);
`ifdef STEP_SCHEDULER_SWING_EN
        w_swing_clamp = (i_swing > i_period) ? i_period : i_swing;
        w_term = r_odd ? ({1'b0, r_period_q} - {1'b0, r_swing_q})
                       : ({1'b0, r_period_q} + {1'b0, r_swing_q});
`else
        w_term = {1'b0, r_period_q};
`endif
        o_last = (r_cnt == w_term);
    end

    // Counter, boundary reload and gate register.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt      <= '0;
            r_period_q <= '0;
            r_gate_q   <= '0;
            r_gate     <= 1'b0;
`ifdef STEP_SCHEDULER_SWING_EN
            r_odd      <= 1'b0;
            r_swing_q  <= '0;
`endif
        end else if (i_start) begin
            r_cnt      <= '0;
            r_period_q <= i_period;
            r_gate_q   <= i_gate_len;
            r_gate     <= (i_gate_len != '0);
`ifdef STEP_SCHEDULER_SWING_EN
            r_odd      <= 1'b0;
            r_swing_q  <= w_swing_clamp;
`endif
        end else if (i_hold) begin
            r_gate <= 1'b0;
        end else if (i_en) begin
            if (o_last) begin
                r_cnt      <= '0;
                r_period_q <= i_period;
                r_gate_q   <= i_gate_len;
                r_gate     <= (i_gate_len != '0);
`ifdef STEP_SCHEDULER_SWING_EN
                r_odd      <= ~r_odd;
                // Swing is only sampled when the step being entered is even.
                if (r_odd) begin
                    r_swing_q <= w_swing_clamp;
                end else begin
                    r_swing_q <= r_swing_q;
                end
`endif
            end else begin
                r_cnt  <= w_cnt_inc;
                r_gate <= (w_cnt_inc < {1'b0, r_gate_q});
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_gate = r_gate;

endmodule

// File: rtl/step_scheduler.sv
// Play-mode step scheduler: FSM, step index/one-hot and registered sample enables.
// Optional STEP_SCHEDULER_SWING_EN adds the swing input.
module step_scheduler
    import drum_pkg::*;
#(
    parameter int NSTEPS = 8,
    parameter int CNT_W  = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      hold,
    input  logic [CNT_W-1:0]          step_period,
    input  logic [CNT_W-1:0]          gate_len,
`ifdef STEP_SCHEDULER_SWING_EN
    input  logic [CNT_W-1:0]          swing,
`endif
    input  logic [3:0]                step_smpl,
    input  logic [3:0]                live_smpl,
    output logic [$clog2(NSTEPS)-1:0] step_idx,
    output logic [NSTEPS-1:0]         step_onehot,
    output logic                      step_tick,
    output logic                      gate,
    output logic [3:0]                play_smpl
);

    localparam int                IDX_W      = $clog2(NSTEPS);
    localparam logic [NSTEPS-1:0] ONEHOT_MSB = {1'b1, {(NSTEPS-1){1'b0}}};

    sched_state_t      r_state;
    logic [IDX_W-1:0]  r_step_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [NSTEPS-1:0] r_onehot;
    logic [NSTEPS-1:0] w_onehot_next;
    logic              r_tick;
    smpl_t             r_play;
    logic              w_start;
    logic              w_clear;
    logic              w_hold;
    logic              w_en;
    logic              w_last;
    logic              w_gate;

    // Timer controls; a low run overrides hold in every state.
    always_comb begin
        w_start       = (r_state == IDLE) && run;
        w_clear       = !run;
        w_hold        = (r_state == RUN) && run && hold;
        w_en          = (r_state == RUN) && run && !hold;
        w_idx_next    = r_step_idx + IDX_W'(1);
        w_onehot_next = ONEHOT_MSB >> w_idx_next;
    end

    step_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_clear    (w_clear),
        .i_hold     (w_hold),
        .i_en       (w_en),
        .i_period   (step_period),
        .i_gate_len (gate_len),
`ifdef STEP_SCHEDULER_SWING_EN
        .i_swing    (swing),
`endif
        .o_last     (w_last),
        .o_gate     (w_gate)
    );

    // Scheduler FSM with step position, tick and sample-enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_step_idx <= '0;
            r_onehot   <= '0;
            r_tick     <= 1'b0;
            r_play     <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    r_play <= live_smpl;
                    if (run) begin
                        r_state    <= RUN;
                        r_step_idx <= '0;
                        r_onehot   <= ONEHOT_MSB;
                        r_tick     <= 1'b1;
                    end else begin
                        r_state    <= IDLE;
                        r_step_idx <= '0;
                        r_onehot   <= '0;
                        r_tick     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        r_state    <= IDLE;
                        r_step_idx <= '0;
                        r_onehot   <= '0;
                        r_tick     <= 1'b0;
                        r_play     <= live_smpl;
                    end else if (hold) begin
                        r_tick <= 1'b0;
                        r_play <= live_smpl;
                    end else begin
                        // step_smpl follows step_idx, so this lags gate by one cycle.
                        r_play <= gate_smpl(w_gate, step_smpl) | live_smpl;
                        if (w_last) begin
                            r_step_idx <= w_idx_next;
                            r_onehot   <= w_onehot_next;
                            r_tick     <= 1'b1;
                        end else begin
                            r_tick <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_step_idx <= '0;
                    r_onehot   <= '0;
                    r_tick     <= 1'b0;
                    r_play     <= 4'b0000;
                end
            endcase
        end
    end

    assign step_idx    = r_step_idx;
    assign step_onehot = r_onehot;
    assign step_tick   = r_tick;
    assign gate        = w_gate;
    assign play_smpl   = r_play;

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: per-cycle reference model, a vector
// table, directed corner sequences and randomized play/hold/reset stimulus.
module tb_step_scheduler;

    localparam int NSTEPS = 8;
    localparam int CNT_W  = 20;

    logic              clk = 1'b0;
    logic              rst, run, hold;
    logic [CNT_W-1:0]  step_period, gate_len;
`ifdef STEP_SCHEDULER_SWING_EN
    logic [CNT_W-1:0]  swing;
`endif
    logic [3:0]        step_smpl, live_smpl;
    logic [2:0]        step_idx;
    logic [7:0]        step_onehot;
    logic              step_tick, gate;
    logic [3:0]        play_smpl;

    always #5 clk = ~clk;

    step_scheduler #(.NSTEPS(NSTEPS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .hold        (hold),
        .step_period (step_period),
        .gate_len    (gate_len),
`ifdef STEP_SCHEDULER_SWING_EN
        .swing       (swing),
`endif
        .step_smpl   (step_smpl),
        .live_smpl   (live_smpl),
        .step_idx    (step_idx),
        .step_onehot (step_onehot),
        .step_tick   (step_tick),
        .gate        (gate),
        .play_smpl   (play_smpl)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] pat [NSTEPS];

    // Reference model: elapsed cycles within a step of latched length.
    bit         m_run;
    int         m_idx, m_e, m_len, m_gl, m_sw, m_k;
    bit         m_tick, m_gate;
    logic [3:0] m_play;

    typedef struct {
        int         k;
        int         idx;
        bit         tick;
        bit         gt;
        logic [3:0] play;
        logic [7:0] oh;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int swing_now();
`ifdef STEP_SCHEDULER_SWING_EN
        return (swing > step_period) ? int'(step_period) : int'(swing);
`else
        return 0;
`endif
    endfunction

    function automatic int step_len(input int idx, input int sw);
        if (idx % 2 == 0) return int'(step_period) + sw + 1;
        else              return int'(step_period) - sw + 1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_idx = 0; m_e = 0; m_tick = 0; m_gate = 0; m_play = 4'b0000; m_k = -1;
        end else if (!run) begin
            m_run = 0; m_idx = 0; m_e = 0; m_tick = 0; m_gate = 0; m_play = live_smpl; m_k = -1;
        end else if (!m_run) begin
            m_play = live_smpl;
            m_run = 1; m_idx = 0; m_e = 0; m_k = 0;
            m_sw = swing_now();
            m_len = step_len(0, m_sw);
            m_gl = int'(gate_len);
            m_tick = 1; m_gate = (m_gl > 0);
        end else if (hold) begin
            m_play = live_smpl; m_tick = 0; m_gate = 0;
        end else begin
            m_play = (m_gate ? step_smpl : 4'b0000) | live_smpl;
            m_k++;
            if (m_e == m_len - 1) begin
                m_idx = (m_idx + 1) % NSTEPS;
                m_e = 0;
                if (m_idx % 2 == 0) m_sw = swing_now();
                m_len = step_len(m_idx, m_sw);
                m_gl = int'(gate_len);
                m_tick = 1; m_gate = (m_gl > 0);
            end else begin
                m_e++;
                m_tick = 0; m_gate = (m_e < m_gl);
            end
        end
    endtask

    task automatic cycle();
        logic [7:0] oh;
        @(posedge clk);
        #1;
        model_edge();
        oh = m_run ? (8'b1000_0000 >> m_idx) : 8'b0000_0000;
        chk("model_idx",  step_idx,    m_idx);
        chk("model_oh",   step_onehot, oh);
        chk("model_tick", step_tick,   m_tick);
        chk("model_gate", gate,        m_gate);
        chk("model_play", play_smpl,   m_play);
        step_smpl = pat[m_idx];
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!step_tick && n < 100);
        if (!step_tick) chk("tick_timeout", n, -1);
    endtask

    task automatic restart();
        run = 1'b0;
        cycle();
        run = 1'b1;
        cycle();
    endtask

    initial begin
        int n, guard;
        bit gacc;

        vecs[0]  = '{0,  0, 1'b1, 1'b1, 4'b0001, 8'h80};
        vecs[1]  = '{1,  0, 1'b0, 1'b1, 4'b1011, 8'h80};
        vecs[2]  = '{6,  0, 1'b0, 1'b1, 4'b1011, 8'h80};
        vecs[3]  = '{7,  0, 1'b0, 1'b0, 4'b1011, 8'h80};
        vecs[4]  = '{8,  0, 1'b0, 1'b0, 4'b0001, 8'h80};
        vecs[5]  = '{9,  0, 1'b0, 1'b0, 4'b0001, 8'h80};
        vecs[6]  = '{10, 1, 1'b1, 1'b1, 4'b0001, 8'h40};
        vecs[7]  = '{17, 1, 1'b0, 1'b0, 4'b1011, 8'h40};
        vecs[8]  = '{70, 7, 1'b1, 1'b1, 4'b0001, 8'h01};
        vecs[9]  = '{79, 7, 1'b0, 1'b0, 4'b0001, 8'h01};
        vecs[10] = '{80, 0, 1'b1, 1'b1, 4'b0001, 8'h80};
        vecs[11] = '{85, 0, 1'b0, 1'b1, 4'b1011, 8'h80};

        rst = 1'b1; run = 1'b0; hold = 1'b0;
        step_period = 20'd9; gate_len = 20'd7;
`ifdef STEP_SCHEDULER_SWING_EN
        swing = 20'd0;
`endif
        live_smpl = 4'b0001; step_smpl = 4'b0000;
        for (int i = 0; i < NSTEPS; i++) pat[i] = 4'b1010;
        m_run = 0; m_idx = 0; m_e = 0; m_len = 1; m_gl = 0; m_sw = 0; m_k = -1;
        m_tick = 0; m_gate = 0; m_play = 4'b0000;

        cycle();
        cycle();
        chk("rst_idx",  step_idx,    0);
        chk("rst_oh",   step_onehot, 0);
        chk("rst_tick", step_tick,   0);
        chk("rst_gate", gate,        0);
        chk("rst_play", play_smpl,   0);

        // Table: period 9, gate 7, pattern 1010, live 0001.
        rst = 1'b0; run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            guard = 0;
            while (m_k != vecs[i].k && guard < 200) begin
                cycle();
                guard++;
            end
            if (guard >= 200) chk("vec_timeout", i, -1);
            chk("vec_idx",  step_idx,    vecs[i].idx);
            chk("vec_tick", step_tick,   vecs[i].tick);
            chk("vec_gate", gate,        vecs[i].gt);
            chk("vec_play", play_smpl,   vecs[i].play);
            chk("vec_oh",   step_onehot, vecs[i].oh);
        end

        // run drops mid-step.
        run = 1'b0;
        cycle();
        chk("drop_oh",   step_onehot, 0);
        chk("drop_idx",  step_idx,    0);
        chk("drop_gate", gate,        0);
        chk("drop_play", play_smpl,   4'b0001);

        // rst mid-step clears play_smpl too.
        run = 1'b1;
        cycle(); cycle(); cycle();
        rst = 1'b1;
        cycle();
        chk("rst2_oh",   step_onehot, 0);
        chk("rst2_gate", gate,        0);
        chk("rst2_play", play_smpl,   0);
        rst = 1'b0;

        // Period change mid-step takes effect at the next boundary.
        restart();
        cycle(); cycle(); cycle();
        step_period = 20'd4;
        wait_tick(n); chk("pchg_first",  n, 7);
        wait_tick(n); chk("pchg_second", n, 5);
        wait_tick(n); chk("pchg_third",  n, 5);

        // Hold for 6 cycles at cnt 5.
        step_period = 20'd9;
        restart();
        for (int i = 0; i < 5; i++) cycle();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("hold_gate", gate,      0);
            chk("hold_play", play_smpl, live_smpl);
            chk("hold_tick", step_tick, 0);
        end
        hold = 1'b0;
        wait_tick(n);
        chk("hold_delay", n + 6, 5 + 6);

        // Gate length extremes.
        gate_len = 20'd0;
        restart();
        gacc = gate;
        for (int i = 0; i < 30; i++) begin cycle(); gacc = gacc | gate; end
        chk("gate_zero", gacc, 0);
        gate_len = 20'd50;
        restart();
        gacc = gate;
        for (int i = 0; i < 30; i++) begin cycle(); gacc = gacc & gate; end
        chk("gate_full", gacc, 1);
        gate_len = 20'd7;

`ifdef STEP_SCHEDULER_SWING_EN
        swing = 20'd3;
        restart();
        wait_tick(n); chk("swing_0", n, 13);
        wait_tick(n); chk("swing_1", n, 7);
        wait_tick(n); chk("swing_2", n, 13);
        wait_tick(n); chk("swing_3", n, 7);
        swing = 20'd0;
`endif

        // Randomized play against the reference model.
        for (int i = 0; i < NSTEPS; i++) pat[i] = 4'($urandom_range(0, 15));
        step_period = 20'd2;
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) run = ~run;
            hold = ($urandom_range(0, 7) == 0);
            live_smpl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`ifdef STEP_SCHEDULER_SWING_EN
            if ($urandom_range(0, 9) == 0) step_period = 20'($urandom_range(3, 6));
            if ($urandom_range(0, 9) == 0) swing = 20'($urandom_range(0, 3));
`else
            if ($urandom_range(0, 9) == 0) step_period = 20'($urandom_range(0, 5));
`endif
            if ($urandom_range(0, 9) == 0) gate_len = 20'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
